// File: rtl/fft_frame_packer_if.sv
// Beat stream between the upstream producer, the frame packer and the first butterfly stage.
// master = producer/consumer side, slave = packer side.
interface fft_frame_packer_if #(
    parameter int LANES = 16,
    parameter int W     = 13
);
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_r [0:LANES-1];
    logic signed [W-1:0] in_i [0:LANES-1];
    logic                dout_start;
    logic                dout_active;
    logic                dout_last;
    logic signed [W-1:0] dout_r [0:LANES-1];
    logic signed [W-1:0] dout_i [0:LANES-1];

    modport master (
        output in_valid, in_r, in_i,
        input  in_ready, dout_start, dout_active, dout_last, dout_r, dout_i
    );

    modport slave (
        input  in_valid, in_r, in_i,
        output in_ready, dout_start, dout_active, dout_last, dout_r, dout_i
    );
endinterface

// File: rtl/fft_frame_packer.sv
// Buffers BEATS beats of LANES complex samples and replays each frame gap-free with a start pulse.
// FFT_PACKER_PINGPONG_EN defined: two banks that fill and send concurrently; undefined: single bank.
module fft_frame_packer #(
    parameter int LANES = 16,
    parameter int BEATS = 32,
    parameter int W     = 13
) (
    input logic               clk,
    input logic               rst,
    fft_frame_packer_if.slave bus
);
    localparam int               IDX_W    = $clog2(BEATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    wr_idx, rd_idx;
    logic                accept, wr_last;
    logic                fill_full, send_full;
    logic                issue_p0, start_p0, last_p0;
    logic signed [W-1:0] rd_r_p0 [0:LANES-1];
    logic signed [W-1:0] rd_i_p0 [0:LANES-1];
    logic                vld_p1, start_p1, last_p1;
    logic signed [W-1:0] beat_r_p1 [0:LANES-1];
    logic signed [W-1:0] beat_i_p1 [0:LANES-1];

`ifdef FFT_PACKER_PINGPONG_EN
    logic                fill_ptr, send_ptr;
    logic [1:0]          full;
    logic signed [W-1:0] mem_r [0:1][0:BEATS-1][0:LANES-1];
    logic signed [W-1:0] mem_i [0:1][0:BEATS-1][0:LANES-1];

    assign fill_full = full[fill_ptr];
    assign send_full = full[send_ptr];
`else
    logic                full;
    logic signed [W-1:0] mem_r [0:BEATS-1][0:LANES-1];
    logic signed [W-1:0] mem_i [0:BEATS-1][0:LANES-1];

    assign fill_full = full;
    assign send_full = full;
`endif

    // Held low during reset so nothing is accepted before the flags are cleared.
    assign bus.in_ready = !rst && !fill_full;
    assign accept       = bus.in_valid && bus.in_ready;
    assign wr_last      = accept && (wr_idx == LAST_IDX);

    always_comb begin
        state_d  = state_q;
        issue_p0 = 1'b0;
        start_p0 = 1'b0;
        last_p0  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (send_full) begin
                    issue_p0 = 1'b1;
                    start_p0 = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                issue_p0 = 1'b1;
                if (rd_idx == LAST_IDX) begin
                    last_p0 = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The bank is released on the edge that registers its last beat, so a full partner
    // bank starts in the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_idx  <= '0;
            rd_idx  <= '0;
`ifdef FFT_PACKER_PINGPONG_EN
            full     <= '0;
            fill_ptr <= 1'b0;
            send_ptr <= 1'b0;
`else
            full     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                wr_idx <= wr_last ? '0 : wr_idx + 1'b1;
            end
            if (issue_p0) begin
                rd_idx <= last_p0 ? '0 : rd_idx + 1'b1;
            end
`ifdef FFT_PACKER_PINGPONG_EN
            if (wr_last) begin
                full[fill_ptr] <= 1'b1;
                fill_ptr       <= ~fill_ptr;
            end
            if (last_p0) begin
                full[send_ptr] <= 1'b0;
                send_ptr       <= ~send_ptr;
            end
`else
            if (wr_last) begin
                full <= 1'b1;
            end else if (last_p0) begin
                full <= 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < LANES; k++) begin
`ifdef FFT_PACKER_PINGPONG_EN
                mem_r[fill_ptr][wr_idx][k] <= bus.in_r[k];
                mem_i[fill_ptr][wr_idx][k] <= bus.in_i[k];
`else
                mem_r[wr_idx][k] <= bus.in_r[k];
                mem_i[wr_idx][k] <= bus.in_i[k];
`endif
            end
        end
    end

    // p0: read the beat selected by the send bank and read index
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
`ifdef FFT_PACKER_PINGPONG_EN
            rd_r_p0[k] = mem_r[send_ptr][rd_idx][k];
            rd_i_p0[k] = mem_i[send_ptr][rd_idx][k];
`else
            rd_r_p0[k] = mem_r[rd_idx][k];
            rd_i_p0[k] = mem_i[rd_idx][k];
`endif
        end
    end

    // p1: registered output beat and strobes; data is forced to zero whenever no beat issues
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            start_p1 <= 1'b0;
            last_p1  <= 1'b0;
        end else begin
            vld_p1   <= issue_p0;
            start_p1 <= start_p0;
            last_p1  <= last_p0;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (rst || !issue_p0) begin
                beat_r_p1[k] <= '0;
                beat_i_p1[k] <= '0;
            end else begin
                beat_r_p1[k] <= rd_r_p0[k];
                beat_i_p1[k] <= rd_i_p0[k];
            end
        end
    end

    assign bus.dout_start  = start_p1;
    assign bus.dout_active = vld_p1;
    assign bus.dout_last   = last_p1;
    assign bus.dout_r      = beat_r_p1;
    assign bus.dout_i      = beat_i_p1;
endmodule

// File: tb/tb_fft_frame_packer.sv
// Randomized bench for fft_frame_packer: a frame-queue model predicts in_ready and every output beat.
// Builds with or without FFT_PACKER_PINGPONG_EN.
module tb_fft_frame_packer;
    localparam int LANES = 16;
    localparam int BEATS = 32;
    localparam int W     = 13;
    localparam int BW    = 2 * LANES * W;
`ifdef FFT_PACKER_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    typedef logic [BW-1:0] beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_frame_packer_if #(.LANES(LANES), .W(W)) bus ();

    fft_frame_packer #(.LANES(LANES), .BEATS(BEATS), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_acc_cyc = 0;

    // Model: complete frames wait in m_q; m_pos is the next beat of the frame in flight (0 = none).
    beat_t m_q[$];
    beat_t m_fill[$];
    int    m_pend = 0;
    int    m_pos  = 0;
    logic  exp_act = 1'b0, exp_start = 1'b0, exp_last = 1'b0;
    beat_t exp_data = '0;

    int start_q[$];
    int last_q[$];
    logic signed [W-1:0] cap0_r [LANES];
    logic signed [W-1:0] cap0_i [LANES];
    logic signed [W-1:0] capl_r [LANES];
    logic signed [W-1:0] capl_i [LANES];

    task automatic chk_ok(input string name, input bit ok, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_int(input string name, input longint act, input longint exp);
        chk_ok(name, act == exp, act, exp);
    endtask

    task automatic chk_beat(input string name, input beat_t act, input beat_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    endtask

    always @(posedge clk) begin : model
        bit    acc;
        int    used;
        beat_t b;
        cyc++;
        used = m_pend + ((m_pos > 0) ? 1 : 0);
        acc  = !rst && bus.in_valid && (used < NB);
        if (rst) begin
            m_q.delete();
            m_fill.delete();
            m_pend    = 0;
            m_pos     = 0;
            exp_act   = 1'b0;
            exp_start = 1'b0;
            exp_last  = 1'b0;
            exp_data  = '0;
        end else begin
            exp_act   = 1'b0;
            exp_start = 1'b0;
            exp_last  = 1'b0;
            exp_data  = '0;
            if (m_pos > 0) begin
                exp_act  = 1'b1;
                exp_data = m_q.pop_front();
                exp_last = (m_pos == BEATS - 1);
                m_pos    = (m_pos == BEATS - 1) ? 0 : m_pos + 1;
            end else if (m_pend > 0) begin
                m_pend--;
                exp_act   = 1'b1;
                exp_start = 1'b1;
                exp_data  = m_q.pop_front();
                m_pos     = 1;
            end
            if (acc) begin
                for (int k = 0; k < LANES; k++) begin
                    b[k*2*W +: W]     = bus.in_r[k];
                    b[k*2*W + W +: W] = bus.in_i[k];
                end
                m_fill.push_back(b);
                if (m_fill.size() == BEATS) begin
                    foreach (m_fill[j]) m_q.push_back(m_fill[j]);
                    m_fill.delete();
                    m_pend++;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        beat_t got;
        bit    exp_ready;
        if (cyc >= 1) begin
            exp_ready = !rst && ((m_pend + ((m_pos > 0) ? 1 : 0)) < NB);
            chk_int("in_ready", bus.in_ready, exp_ready);
            chk_int("strobes{start,active,last}", {bus.dout_start, bus.dout_active, bus.dout_last},
                    {exp_start, exp_act, exp_last});
            for (int k = 0; k < LANES; k++) begin
                got[k*2*W +: W]     = bus.dout_r[k];
                got[k*2*W + W +: W] = bus.dout_i[k];
            end
            chk_beat("dout_data", got, exp_data);
            if (bus.dout_start) begin
                start_q.push_back(cyc);
                for (int k = 0; k < LANES; k++) begin
                    cap0_r[k] = bus.dout_r[k];
                    cap0_i[k] = bus.dout_i[k];
                end
            end
            if (bus.dout_last) begin
                last_q.push_back(cyc);
                for (int k = 0; k < LANES; k++) begin
                    capl_r[k] = bus.dout_r[k];
                    capl_i[k] = bus.dout_i[k];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind 0: n*16+k with negated imag; kind 1: full-scale extremes; kind 2: random
    task automatic drive_beat(input int kind, input int n, input bit valid);
        int r, i;
        for (int k = 0; k < LANES; k++) begin
            if (!valid || kind == 2) begin
                r = int'($urandom_range(8191)) - 4096;
                i = int'($urandom_range(8191)) - 4096;
            end else if (kind == 0) begin
                r = n * LANES + k;
                i = -r;
            end else begin
                r = ((n + k) % 2 == 1) ? 4095 : -4096;
                i = -r - 1;
            end
            bus.in_r[k] = W'(r);
            bus.in_i[k] = W'(i);
        end
        bus.in_valid = valid;
    endtask

    task automatic send_beats(input int kind, input int nbeats, input int duty);
        int b      = 0;
        int budget = nbeats * 20 + 200;
        bit v;
        while (b < nbeats && budget > 0) begin
            v = (int'($urandom_range(99)) < duty);
            drive_beat(kind, b % BEATS, v);
            @(negedge clk);
            if (v && bus.in_ready) begin
                b++;
                last_acc_cyc = cyc;
            end
            tick();
            budget--;
        end
        bus.in_valid = 1'b0;
        if (b < nbeats) chk_ok("send_budget", 1'b0, b, nbeats);
    endtask

    task automatic wait_beats(input int n);
        int seen   = 0;
        int budget = 200;
        while (seen < n && budget > 0) begin
            @(negedge clk);
            if (bus.dout_active) seen++;
            budget--;
        end
        if (seen < n) chk_ok("wait_beats", 1'b0, seen, n);
        tick();
    endtask

    task automatic clear_logs();
        start_q.delete();
        last_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        drive_beat(0, 0, 1'b0);
        rst = 1'b1;
        repeat (3) tick();
        chk_int("ready_in_reset", bus.in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk_int("ready_after_reset", bus.in_ready, 1);
        tick();

        // Gap-free ramp frame
        clear_logs();
        send_beats(0, BEATS, 100);
        repeat (45) tick();
        chk_int("t1_starts", start_q.size(), 1);
        chk_int("t1_latency", (start_q.size() > 0) ? start_q[0] - last_acc_cyc : -1, 2);
        chk_int("t1_len", (start_q.size() > 0 && last_q.size() > 0) ? last_q[0] - start_q[0] : -1, 31);
        chk_int("t1_b0_l5_r", cap0_r[5], 5);
        chk_int("t1_b0_l5_i", cap0_i[5], -5);
        chk_int("t1_b31_l15_r", capl_r[15], 511);
        chk_int("t1_b31_l15_i", capl_i[15], -511);
        chk_int("t1_idle_active", bus.dout_active, 0);

        // Same frame with ~50% valid duty
        clear_logs();
        send_beats(0, BEATS, 50);
        repeat (45) tick();
        chk_int("t2_starts", start_q.size(), 1);
        chk_int("t2_len", (start_q.size() > 0 && last_q.size() > 0) ? last_q[0] - start_q[0] : -1, 31);
        chk_int("t2_b0_l7_r", cap0_r[7], 7);

        // Three random frames streamed continuously
        clear_logs();
        send_beats(2, 3 * BEATS, 100);
        repeat (80) tick();
        chk_int("t3_starts", start_q.size(), 3);
`ifdef FFT_PACKER_PINGPONG_EN
        chk_int("t3_gap1", (start_q.size() > 1 && last_q.size() > 0) ? start_q[1] - last_q[0] : -1, 1);
        chk_int("t3_gap2", (start_q.size() > 2 && last_q.size() > 1) ? start_q[2] - last_q[1] : -1, 1);
`else
        chk_ok("t3_gap1", (start_q.size() > 1 && last_q.size() > 0) && (start_q[1] - last_q[0] >= 33),
               (start_q.size() > 1 && last_q.size() > 0) ? start_q[1] - last_q[0] : -1, 33);
        chk_ok("t3_gap2", (start_q.size() > 2 && last_q.size() > 1) && (start_q[2] - last_q[1] >= 33),
               (start_q.size() > 2 && last_q.size() > 1) ? start_q[2] - last_q[1] : -1, 33);
`endif

        // Full-scale extremes
        clear_logs();
        send_beats(1, BEATS, 100);
        repeat (45) tick();
        chk_int("t4_b0_l0_r", cap0_r[0], -4096);
        chk_int("t4_b0_l1_r", cap0_r[1], 4095);
        chk_int("t4_b0_l0_i", cap0_i[0], 4095);
        chk_int("t4_b31_l0_r", capl_r[0], 4095);

        // Reset at beat 20 of a fill discards the partial frame
        clear_logs();
        send_beats(0, 20, 100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (60) tick();
        chk_int("t5_no_start", start_q.size(), 0);
        send_beats(0, BEATS, 100);
        repeat (45) tick();
        chk_int("t5_fresh_starts", start_q.size(), 1);
        chk_int("t5_fresh_b0_l3_r", cap0_r[3], 3);

        // Reset at beat 10 of a send truncates it for good
        clear_logs();
        send_beats(2, BEATS, 100);
        wait_beats(10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_int("t6_zero_after_rst", {bus.dout_start, bus.dout_active, bus.dout_last}, 0);
        tick();
        repeat (60) tick();
        chk_int("t6_starts_after_rst", start_q.size(), 1);
        chk_int("t6_no_last", last_q.size(), 0);
        send_beats(0, BEATS, 100);
        repeat (45) tick();
        chk_int("t6_fresh_starts", start_q.size(), 2);
        chk_int("t6_fresh_lasts", last_q.size(), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fft_frame_packer.md
# fft_frame_packer

Frame source for the FFT first butterfly stage. Accepts 16-lane complex beats from an upstream producer under a valid/ready handshake, possibly with gaps, and buffers 32 beats (one 512-point frame). It then replays the frame as 32 gap-free consecutive beats with a single-cycle start pulse on beat 0. This is the form the stage-2 butterfly input expects: one `din_valid` pulse followed by 32 back-to-back beats, with no backpressure.

## Interface
Parameters:
- `LANES`, 16, complex samples per beat
- `BEATS`, 32, beats per frame
- `W`, 13, signed width of each real/imag sample

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  upstream beat valid
- `in_ready`  out  1  packer can accept a beat
- `in_r[0:LANES-1]`, `in_i[0:LANES-1]`  in  W each, signed  upstream beat
- `dout_start`  out  1  one-cycle pulse on beat 0 of an output frame; drives downstream `din_valid`
- `dout_active`  out  1  high on all 32 output beats
- `dout_last`  out  1  high on beat 31
- `dout_r[0:LANES-1]`, `dout_i[0:LANES-1]`  out  W each, signed  output beat, registered

## Operation
- Storage: two banks (A, B) of `BEATS` x `LANES` complex words, each with a FULL/EMPTY flag. The fill pointer selects the write bank and the send pointer selects the read bank. Both pointers reset to A.
- Fill side:
  - A beat is accepted when `in_valid && in_ready`. It is written at the 5-bit write index, which then increments.
  - The beat written at index 31 sets the write bank FULL, clears the index, and toggles the fill pointer.
  - `in_ready` = fill bank EMPTY.
- Send FSM states: IDLE, SEND.
  - IDLE -> SEND when the send bank is FULL. That cycle registers beat 0 onto `dout_*` and asserts `dout_start` and `dout_active`.
  - SEND: the read index increments each cycle with no stall. Beat 31 asserts `dout_last`.
  - After beat 31, the send bank becomes EMPTY and the send pointer toggles.
  - If the other bank is already FULL, beat 0 of the next frame is issued in the very next cycle (back-to-back, `dout_start` again). Otherwise the FSM returns to IDLE.
- Idle outputs: `dout_r`/`dout_i` = 0 and all strobes are 0 whenever no beat is issued.
- Data path is pass-through with no width change, rounding, or reordering. Lane k of input beat n appears on lane k of output beat n.
- Simultaneous events:
  - Filling bank X while sending bank Y is legal.
  - A bank emptied at edge E is visible as EMPTY (`in_ready`=1) in the cycle after E.
- Partial frames are never emitted.

## Timing
- Reset: `in_ready`=0 while `rst` is high, and 1 from the first cycle after release. All `dout_*` outputs are 0. Both banks are EMPTY and both indices are 0.
- Latency: beat 31 is accepted at edge E. If the FSM is IDLE, beat 0 appears on outputs after edge E+1 and beat 31 after edge E+32.
- Throughput: sustained 1 beat/cycle in both directions when the upstream never gaps.
- Reset mid-fill or mid-send: all contents are discarded and outputs are zero in the next cycle. No truncated output frame is resumed.
- `in_*` values with `in_valid`=0, or while `in_ready`=0, are ignored.

## Configuration
- `FFT_PACKER_PINGPONG_EN`:
  - Defined: two banks as described; fill and send overlap.
  - Undefined: bank B and both pointers are removed. The single bank is written, then sent. `in_ready`=0 from the acceptance of beat 31 until the cycle after beat 31 is sent. Back-to-back output frames are impossible, so there is a minimum gap of 32 fill cycles between frames.

## Test plan
- Reset release, then 32 gap-free beats where lane k of beat n = n*16+k (imag = negated real) -> `dout_start` once 1 cycle after the last accept. Output beats match exactly. `dout_last` on beat 31. Outputs return to 0 afterwards.
- Same frame with `in_valid` toggled randomly (about 50% duty) -> identical output, 32 contiguous `dout_active` cycles.
- Ping-pong, 3 frames streamed continuously -> frames 2 and 3 each start the cycle after the previous `dout_last`. `in_ready` drops only when both banks are FULL.
- Extreme values: lanes at +4095 and -4096 -> bit-exact passthrough.
- Assert `rst` for 1 cycle at beat 10 of send and beat 20 of fill -> outputs 0 next cycle, no further `dout_start`. A fresh frame afterwards is emitted correctly.
- Build without `FFT_PACKER_PINGPONG_EN`: stream 2 frames -> `in_ready`=0 for beats 0-31 of send. Second frame `dout_start` occurs at least 33 cycles after the first frame's `dout_last`.
